// File: rtl/semaforo_pkg.sv
// Shared lamp encodings, decoded state values and error-bit indices for the
// traffic-light monitor and its siblings.
package semaforo_pkg;

  localparam logic [2:0] LAMP_GREEN  = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b001;

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_RED    = 2'd2,
    ST_INV    = 2'd3
  } lamp_st_e;

  localparam int ERR_W       = 5;
  localparam int ERR_A_CODE  = 0;
  localparam int ERR_A_TRANS = 1;
  localparam int ERR_A_DWELL = 2;
  localparam int ERR_B_CODE  = 3;
  localparam int ERR_B_TRANS = 4;

  // One-hot lamp code to colour; anything else is invalid.
  function automatic lamp_st_e lamp_decode(input logic [2:0] code);
    case (code)
      LAMP_GREEN:  return ST_GREEN;
      LAMP_YELLOW: return ST_YELLOW;
      LAMP_RED:    return ST_RED;
      default:     return ST_INV;
    endcase
  endfunction

  // Holding or stepping forward in the G->Y->R->G ring is legal.
  function automatic logic trans_legal(input lamp_st_e from, input lamp_st_e to);
    return (from == to) ||
           (from == ST_GREEN  && to == ST_YELLOW) ||
           (from == ST_YELLOW && to == ST_RED) ||
           (from == ST_RED    && to == ST_GREEN);
  endfunction

endpackage

// File: rtl/lamp_checker.sv
// Per-lamp decode, sync tracking and transition check. Event outputs are
// combinational views of the current sample against the registered state;
// the parent registers whatever it derives from them.
module lamp_checker
  import semaforo_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] code_i,
  output lamp_st_e   state_o,
  output logic       ill_code_o,
  output logic       ill_trans_o,
  output logic       resync_o,
  output logic       change_o
);

  lamp_st_e state_q;
  logic     sync_q;
  lamp_st_e dec;
  logic     legal;

  // Classify the current sample relative to the last one.
  always_comb begin
    dec         = lamp_decode(code_i);
    legal       = (dec != ST_INV);
    ill_code_o  = !legal;
    resync_o    = legal && !sync_q;
    change_o    = legal && sync_q && (dec != state_q);
    ill_trans_o = change_o && !trans_legal(state_q, dec);
  end

  // Follow the lamp unconditionally; an illegal code drops sync.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_INV;
      sync_q  <= 1'b0;
    end else begin
      state_q <= dec;
      sync_q  <= legal;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/semaforo_monitor.sv
// Two-lamp traffic-light monitor: code/transition checks on A and B, dwell
// timing and completed-cycle count on A, sticky error flags with a strobe.
module semaforo_monitor
  import semaforo_pkg::*;
#(
  parameter int VERDE    = 8,
  parameter int AMARELO  = 3,
  parameter int VERMELHO = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       A,
  input  logic [2:0]       B,
  input  logic             clr_err,
  output logic [1:0]       a_state,
  output logic [1:0]       b_state,
  output logic [ERR_W-1:0] err,
  output logic             err_pulse,
  output logic [7:0]       cycles
);

  lamp_st_e a_st, b_st;
  logic a_ill_code, a_ill_trans, a_resync, a_change;
  logic b_ill_code, b_ill_trans, b_resync, b_change;

  lamp_checker u_a (
    .clk(clk), .rst(rst), .code_i(A), .state_o(a_st),
    .ill_code_o(a_ill_code), .ill_trans_o(a_ill_trans),
    .resync_o(a_resync), .change_o(a_change)
  );

  lamp_checker u_b (
    .clk(clk), .rst(rst), .code_i(B), .state_o(b_st),
    .ill_code_o(b_ill_code), .ill_trans_o(b_ill_trans),
    .resync_o(b_resync), .change_o(b_change)
  );

  // B has no dwell tracking, so its segment events go nowhere.
  logic unused_b_seg;
  assign unused_b_seg = b_resync ^ b_change;

  logic [8:0]       dwell_q, dwell_d;
  logic             first_q, first_d;
  logic [7:0]       cycles_q, cycles_d;
  logic [ERR_W-1:0] err_q, err_d, ev;
  logic             pulse_d, pulse_q;
  logic [8:0]       req_dwell;
  logic             a_hold;

  // Dwell/cycle bookkeeping and error accumulation for this sample.
  always_comb begin
    case (a_st)
      ST_GREEN:  req_dwell = 9'(VERDE);
      ST_YELLOW: req_dwell = 9'(AMARELO);
      default:   req_dwell = 9'(VERMELHO);
    endcase
    a_hold = !a_ill_code && !a_resync && !a_change;

    dwell_d = dwell_q;
    first_d = first_q;
    if (a_resync) begin
      dwell_d = 9'd1;
      first_d = 1'b1;
    end else if (a_change) begin
      dwell_d = 9'd1;
      first_d = 1'b0;
    end else if (a_hold && dwell_q != 9'h1FF) begin
      dwell_d = dwell_q + 9'd1;
    end

    cycles_d = cycles_q;
    if (a_change && a_st == ST_RED && !a_ill_trans && cycles_q != 8'hFF)
      cycles_d = cycles_q + 8'd1;

    ev              = '0;
    ev[ERR_A_CODE]  = a_ill_code;
    ev[ERR_A_TRANS] = a_ill_trans;
    ev[ERR_A_DWELL] = a_change && !first_q && (dwell_q != req_dwell);
    ev[ERR_B_CODE]  = b_ill_code;
    ev[ERR_B_TRANS] = b_ill_trans;

    // A fresh error alongside clr_err still counts as a new rising flag.
    err_d   = (clr_err ? '0 : err_q) | ev;
    pulse_d = |(ev & (clr_err ? {ERR_W{1'b1}} : ~err_q));
  end

  // Register all monitor state and outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dwell_q  <= '0;
      first_q  <= 1'b0;
      cycles_q <= '0;
      err_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      dwell_q  <= dwell_d;
      first_q  <= first_d;
      cycles_q <= cycles_d;
      err_q    <= err_d;
      pulse_q  <= pulse_d;
    end
  end

  assign a_state   = a_st;
  assign b_state   = b_st;
  assign err       = err_q;
  assign err_pulse = pulse_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_semaforo_monitor.sv
// Directed scoreboard bench for semaforo_monitor.
module tb_semaforo_monitor;

  localparam logic [2:0] G = 3'b100, Y = 3'b010, R = 3'b001;
  localparam logic [4:0] M_ALL = 5'h1F, M_SAT = 5'b10100, M_NONE = 5'h00;

  typedef struct {
    string      name;
    logic [4:0] mask;   // [0]a_state [1]b_state [2]err [3]err_pulse [4]cycles
    logic [1:0] a, b;
    logic [4:0] err;
    logic       p;
    logic [7:0] cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] A = G, B = G;
  logic       clr_err = 1'b0;
  logic [1:0] a_state, b_state;
  logic [4:0] err;
  logic       err_pulse;
  logic [7:0] cycles;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  semaforo_monitor #(.VERDE(8), .AMARELO(3), .VERMELHO(6)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .clr_err(clr_err),
    .a_state(a_state), .b_state(b_state), .err(err),
    .err_pulse(err_pulse), .cycles(cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  // Drive one sample at negedge; queue what the outputs must be after the edge.
  task automatic step(input logic r, input logic [2:0] a, input logic [2:0] b,
                      input logic c, input string nm, input logic [4:0] m,
                      input logic [1:0] ea, input logic [1:0] eb,
                      input logic [4:0] ee, input logic ep, input logic [7:0] ec);
    exp_t e;
    @(negedge clk);
    rst = r; A = a; B = b; clr_err = c;
    @(posedge clk);
    #1;
    if (m != M_NONE) begin
      e.name = nm; e.mask = m; e.a = ea; e.b = eb; e.err = ee; e.p = ep; e.cyc = ec;
      sb.push_back(e);
    end
  endtask

  // Monitor: outputs are stable at negedge, compare against queued expectations.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.mask[0]) begin
        n_chk++;
        if (a_state !== e.a) begin n_err++;
          $display("FAIL %s a_state got %0d exp %0d", e.name, a_state, e.a); end
      end
      if (e.mask[1]) begin
        n_chk++;
        if (b_state !== e.b) begin n_err++;
          $display("FAIL %s b_state got %0d exp %0d", e.name, b_state, e.b); end
      end
      if (e.mask[2]) begin
        n_chk++;
        if (err !== e.err) begin n_err++;
          $display("FAIL %s err got %b exp %b", e.name, err, e.err); end
      end
      if (e.mask[3]) begin
        n_chk++;
        if (err_pulse !== e.p) begin n_err++;
          $display("FAIL %s err_pulse got %b exp %b", e.name, err_pulse, e.p); end
      end
      if (e.mask[4]) begin
        n_chk++;
        if (cycles !== e.cyc) begin n_err++;
          $display("FAIL %s cycles got %0d exp %0d", e.name, cycles, e.cyc); end
      end
    end
  end

  initial begin
    // Reset, with clr_err asserted to show it is ignored.
    step(0, G, G, 1, "reset0", M_ALL, 3, 3, 5'b00000, 0, 0);
    step(0, G, G, 0, "reset1", M_ALL, 3, 3, 5'b00000, 0, 0);

    // One clean A cycle: G x8, Y x3, R x6, G.
    for (int i = 0; i < 8; i++) step(1, G, G, 0, "cyc_green", M_ALL, 0, 0, 5'b00000, 0, 0);
    for (int i = 0; i < 3; i++) step(1, Y, G, 0, "cyc_yellow", M_ALL, 1, 0, 5'b00000, 0, 0);
    for (int i = 0; i < 6; i++) step(1, R, G, 0, "cyc_red", M_ALL, 2, 0, 5'b00000, 0, 0);
    step(1, G, G, 0, "cyc_done", M_ALL, 0, 0, 5'b00000, 0, 1);
    // Complete that green (8 total), then yellow one cycle too long.
    for (int i = 0; i < 7; i++) step(1, G, G, 0, "g2_hold", M_ALL, 0, 0, 5'b00000, 0, 1);
    for (int i = 0; i < 4; i++) step(1, Y, G, 0, "y_long_no_err_yet", M_ALL, 1, 0, 5'b00000, 0, 1);
    step(1, R, G, 0, "dwell_err", M_ALL, 2, 0, 5'b00100, 1, 1);
    step(1, R, G, 0, "dwell_sticky", M_ALL, 2, 0, 5'b00100, 0, 1);
    step(1, R, G, 1, "dwell_clr", M_ALL, 2, 0, 5'b00000, 0, 1);

    // Illegal transition green->red.
    step(0, G, G, 0, "reset2", M_ALL, 3, 3, 5'b00000, 0, 0);
    step(1, G, G, 0, "it_sync", M_ALL, 0, 0, 5'b00000, 0, 0);
    step(1, G, G, 0, "it_hold", M_ALL, 0, 0, 5'b00000, 0, 0);
    step(1, R, G, 0, "it_g2r", M_ALL, 2, 0, 5'b00010, 1, 0);
    step(1, R, G, 0, "it_sticky", M_ALL, 2, 0, 5'b00010, 0, 0);
    // clr_err together with a new illegal code on A.
    step(1, 3'b111, G, 1, "clr_new_code", M_ALL, 3, 0, 5'b00001, 1, 0);
    step(1, R, G, 0, "a_resync", M_ALL, 2, 0, 5'b00001, 0, 0);
    // B multi-hot code, then resync without a transition error.
    step(1, R, 3'b110, 0, "b_bad_code", M_ALL, 2, 3, 5'b01001, 1, 0);
    step(1, R, G, 0, "b_resync", M_ALL, 2, 0, 5'b01001, 0, 0);
    step(1, R, G, 1, "clr2", M_ALL, 2, 0, 5'b00000, 0, 0);
    // Two illegal transitions in one cycle -> both bits, single pulse.
    step(1, Y, R, 0, "dual_err", M_ALL, 1, 2, 5'b10010, 1, 0);
    step(1, Y, R, 0, "dual_hold", M_ALL, 1, 2, 5'b10010, 0, 0);

    // Saturate cycles with 256 legal A cycles.
    step(0, G, G, 0, "reset3", M_ALL, 3, 3, 5'b00000, 0, 0);
    for (int i = 0; i < 8; i++) step(1, G, G, 0, "sat_g0", M_NONE, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 256; k++) begin
      for (int i = 0; i < 3; i++) step(1, Y, G, 0, "sat_y", M_NONE, 0, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) step(1, R, G, 0, "sat_r", M_NONE, 0, 0, 0, 0, 0);
      step(1, G, G, 0, "sat_cycles", M_SAT, 0, 0, 5'b00000, 0, (k > 255) ? 8'd255 : 8'(k));
      for (int i = 0; i < 7; i++) step(1, G, G, 0, "sat_g", M_NONE, 0, 0, 0, 0, 0);
    end
    step(1, G, G, 0, "sat_hold", M_ALL, 0, 0, 5'b00000, 0, 255);
    // Reset mid-green; the next short green is a first segment and exempt.
    step(0, G, G, 0, "reset_mid", M_ALL, 3, 3, 5'b00000, 0, 0);
    for (int i = 0; i < 3; i++) step(1, G, G, 0, "post_rst_g", M_ALL, 0, 0, 5'b00000, 0, 0);
    step(1, Y, G, 0, "post_rst_exempt", M_ALL, 1, 0, 5'b00000, 0, 0);

    repeat (3) @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain queue left %0d exp 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
